// File: rtl/bad_shift_reg_pkg.sv
// Shared defaults for the single-bit delay chain.
package bad_shift_reg_pkg;

    localparam int   SHIFT_DEPTH_DEFAULT     = 2;
    localparam logic SHIFT_RESET_VAL_DEFAULT = 1'b0;
    localparam int   SHIFT_DEPTH_MAX         = 64;

endpackage

// File: rtl/bad_shift_reg_stage.sv
// One link of the delay chain: a D flop with synchronous active-low reset.
module bad_shift_reg_stage
    import bad_shift_reg_pkg::*;
#(
    parameter logic RESET_VAL = SHIFT_RESET_VAL_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic q_d;
    logic q_q;

    assign q_d = d_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bad_shift_reg.sv
// Serial-in/serial-out delay line of DEPTH distinct flops.
module bad_shift_reg
    import bad_shift_reg_pkg::*;
#(
    parameter int   DEPTH     = SHIFT_DEPTH_DEFAULT,
    parameter logic RESET_VAL = SHIFT_RESET_VAL_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic dout
);

    if (DEPTH < 1 || DEPTH > SHIFT_DEPTH_MAX) begin : g_bad_depth
        $error("bad_shift_reg: DEPTH must be in 1..64");
    end

    logic [DEPTH-1:0] stage;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic link_in;
        if (i == 0) begin : g_head
            assign link_in = d;
        end else begin : g_body
            assign link_in = stage[i-1];
        end
        bad_shift_reg_stage #(
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk_i (clk),
            .rst_ni(reset),
            .d_i   (link_in),
            .q_o   (stage[i])
        );
    end

    assign dout = stage[DEPTH-1];

`ifndef SYNTHESIS
    // Once DEPTH clean edges have passed, dout must be d from DEPTH edges ago.
    logic [DEPTH-1:0] hist_q;
    int               run_q;

    always_ff @(posedge clk) begin
        if (run_q >= DEPTH) begin
            assert (dout == hist_q[DEPTH-1])
            else $error("bad_shift_reg: latency violated");
        end
        hist_q <= DEPTH'({hist_q, d});
        if (!reset) begin
            run_q <= 0;
        end else if (run_q < DEPTH) begin
            run_q <= run_q + 1;
        end
    end
`endif

endmodule

// File: tb/tb_bad_shift_reg.sv
// Scoreboard bench for bad_shift_reg at DEPTH 2, 1 and 8.
module tb_bad_shift_reg;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic d = 1'b0;
    logic dout2, dout1, dout8;

    int checks = 0;
    int failures = 0;

    logic [1:0] hist[$];
    logic exp2_q[$];
    logic exp1_q[$];
    logic exp8_q[$];

    always #10 clk = ~clk;

    bad_shift_reg #(.DEPTH(2), .RESET_VAL(1'b0)) dut2 (
        .clk(clk), .reset(reset), .d(d), .dout(dout2));
    bad_shift_reg #(.DEPTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .d(d), .dout(dout1));
    bad_shift_reg #(.DEPTH(8), .RESET_VAL(1'b0)) dut8 (
        .clk(clk), .reset(reset), .d(d), .dout(dout8));

    // Output after edge k is d from edge k-depth+1, provided none of the
    // edges k-depth+1..k was a reset edge; otherwise the reset value.
    function automatic logic expect_out(int depth);
        int k = hist.size() - 1;
        int first = k - depth + 1;
        if (first < 0) return 1'b0;
        for (int j = first; j <= k; j++) begin
            if (hist[j][1] == 1'b0) return 1'b0;
        end
        return hist[first][0];
    endfunction

    task automatic record(input logic r, input logic dv);
        hist.push_back({r, dv});
        exp2_q.push_back(expect_out(2));
        exp1_q.push_back(expect_out(1));
        exp8_q.push_back(expect_out(8));
    endtask

    task automatic step(input logic r, input logic dv);
        @(negedge clk);
        reset = r;
        d = dv;
        @(posedge clk);
        record(r, dv);
    endtask

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%b required=%b",
                     name, hist.size(), act, req);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp2_q.size() > 0) check("depth2", dout2, exp2_q.pop_front());
            if (exp1_q.size() > 0) check("depth1", dout1, exp1_q.pop_front());
            if (exp8_q.size() > 0) check("depth8", dout8, exp8_q.pop_front());
        end
    end

    initial begin : stimulus
        logic [6:0] pat;
        pat = 7'b1001101;
        // Reset held with d=1
        repeat (3) step(1'b0, 1'b1);
        // Single pulse
        step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        // Pattern 1,0,1,1,0,0,1
        for (int i = 0; i < 7; i++) step(1'b1, pat[i]);
        repeat (9) step(1'b1, 1'b0);
        // Slow toggle, asynchronous to clk
        @(negedge clk);
        #3;
        fork
            begin
                repeat (17) begin
                    #173;
                    d = ~d;
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    record(1'b1, d);
                end
            end
        join
        // Reset mid-stream
        repeat (10) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b1);
        // Random stream, then reset and release with d=1 held
        repeat (60) step(1'b1, 1'($urandom_range(1, 0)));
        step(1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b1);
        repeat (40) step(1'b1, 1'($urandom_range(1, 0)));
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp2_q.size() + exp1_q.size() + exp8_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0",
                     exp2_q.size() + exp1_q.size() + exp8_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
